// File: rtl/ex_muldiv_unit_pkg.sv
// Shared types and constants for the EX-stage RV32M multiply/divide engine.
package ex_muldiv_unit_pkg;

  localparam int unsigned MD_XLEN = 32;

  // Operator encoding as carried in ID/EX (funct3 of the M extension).
  typedef enum logic [2:0] {
    OpMul    = 3'd0,
    OpMulh   = 3'd1,
    OpMulhsu = 3'd2,
    OpMulhu  = 3'd3,
    OpDiv    = 3'd4,
    OpDivu   = 3'd5,
    OpRem    = 3'd6,
    OpRemu   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StFix  = 2'd2,
    StDone = 2'd3
  } muldiv_state_e;

  function automatic logic is_div_op(input muldiv_op_e op);
    return op inside {OpDiv, OpDivu, OpRem, OpRemu};
  endfunction

endpackage

// File: rtl/ex_muldiv_unit_sign_fix.sv
// Final sign correction and output-word selection applied in the FIX state.
module ex_muldiv_unit_sign_fix
  import ex_muldiv_unit_pkg::*;
#(
  parameter int unsigned XLEN = MD_XLEN
) (
  input  muldiv_op_e        op,
  input  logic [2*XLEN-1:0] acc,
  input  logic              neg1,
  input  logic              neg2,
  output logic [XLEN-1:0]   word
);

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;

  // acc holds the unsigned product, or {remainder, quotient} after a divide.
  always_comb begin
    prod = (neg1 ^ neg2) ? -acc : acc;
    quo  = (neg1 ^ neg2) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem  = neg1 ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
  end

  // Pick the architectural result word for the operator.
  always_comb begin
    word = '0;
    unique case (op)
      OpMul:                     word = prod[XLEN-1:0];
      OpMulh, OpMulhsu, OpMulhu: word = prod[2*XLEN-1:XLEN];
      OpDiv, OpDivu:             word = quo;
      OpRem, OpRemu:             word = rem;
      default:                   word = '0;
    endcase
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide engine: shift-add multiply and restoring
// divide at one bit per cycle, stalling the pipeline while busy.
module ex_muldiv_unit
  import ex_muldiv_unit_pkg::*;
#(
  parameter int unsigned XLEN = MD_XLEN
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            flush,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CntW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] AllOnes = {XLEN{1'b1}};

  muldiv_state_e     state_q, state_d;
  muldiv_op_e        op_q, op_d;
  logic              neg1_q, neg1_d;
  logic              neg2_q, neg2_d;
  logic [XLEN-1:0]   opa_q, opa_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0]   result_q, result_d;

  muldiv_op_e        op_in;
  logic              sgn1_in, sgn2_in;
  logic              neg1_in, neg2_in;
  logic [XLEN-1:0]   mag1_in, mag2_in;
  logic              div_zero, div_ovf;
  logic [XLEN-1:0]   special_word;

  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_acc;
  logic [XLEN:0]     div_shift;
  logic              div_ge;
  logic [XLEN-1:0]   div_diff;
  logic [XLEN-1:0]   div_rem;
  logic [2*XLEN-1:0] div_acc;

  logic [XLEN-1:0]   fix_word;

  // Decode the incoming operator: signedness, magnitudes and special cases.
  always_comb begin
    op_in   = muldiv_op_e'(op);
    sgn1_in = op_in inside {OpMulh, OpMulhsu, OpDiv, OpRem};
    sgn2_in = op_in inside {OpMulh, OpDiv, OpRem};
    neg1_in = sgn1_in & rs1_data[XLEN-1];
    neg2_in = sgn2_in & rs2_data[XLEN-1];
    mag1_in = neg1_in ? -rs1_data : rs1_data;
    mag2_in = neg2_in ? -rs2_data : rs2_data;

    div_zero = is_div_op(op_in) && (rs2_data == '0);
    div_ovf  = (op_in inside {OpDiv, OpRem}) && (rs1_data == MinNeg) && (rs2_data == AllOnes);

    special_word = '0;
    if (div_zero) begin
      special_word = (op_in inside {OpDiv, OpDivu}) ? AllOnes : rs1_data;
    end else if (div_ovf) begin
      special_word = (op_in == OpDiv) ? MinNeg : '0;
    end
  end

  // One iteration of each datapath; acc[2X-1:X] is the running high half /
  // partial remainder, the low half fills with product or quotient bits.
  always_comb begin
    mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (opb_q[0] ? {1'b0, opa_q} : '0);
    mul_acc = {mul_sum, acc_q[XLEN-1:1]};

    div_shift = {acc_q[2*XLEN-1:XLEN], opa_q[XLEN-1]};
    div_ge    = div_shift >= {1'b0, opb_q};
    // Only used when div_shift >= divisor, so the difference fits XLEN bits.
    div_diff  = div_shift[XLEN-1:0] - opb_q;
    div_rem   = div_ge ? div_diff : div_shift[XLEN-1:0];
    div_acc   = {div_rem, acc_q[XLEN-2:0], div_ge};
  end

  ex_muldiv_unit_sign_fix #(
    .XLEN (XLEN)
  ) u_sign_fix (
    .op   (op_q),
    .acc  (acc_q),
    .neg1 (neg1_q),
    .neg2 (neg2_q),
    .word (fix_word)
  );

  // Next-state logic for the FSM and datapath registers.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    neg1_d   = neg1_q;
    neg2_d   = neg2_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;

    unique case (state_q)
      StIdle: begin
        if (start && !flush) begin
          op_d   = op_in;
          neg1_d = neg1_in;
          neg2_d = neg2_in;
          opa_d  = mag1_in;
          opb_d  = mag2_in;
          acc_d  = '0;
          cnt_d  = '0;
          if (div_zero || div_ovf) begin
            result_d = special_word;
            state_d  = StDone;
          end else begin
            state_d = StRun;
          end
        end
      end
      StRun: begin
        if (is_div_op(op_q)) begin
          acc_d = div_acc;
          opa_d = {opa_q[XLEN-2:0], 1'b0};
        end else begin
          acc_d = mul_acc;
          opb_d = {1'b0, opb_q[XLEN-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(XLEN - 1)) begin
          state_d = StFix;
        end
      end
      StFix: begin
        result_d = fix_word;
        state_d  = StDone;
      end
      StDone: begin
        // A start still held here belongs to the op just finished.
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Redirect aborts whatever is in flight and leaves result untouched.
    if (flush) begin
      state_d  = StIdle;
      result_d = result_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      op_q     <= OpMul;
      neg1_q   <= 1'b0;
      neg2_q   <= 1'b0;
      opa_q    <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      neg1_q   <= neg1_d;
      neg2_q   <= neg2_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  // Pipeline handshake outputs.
  always_comb begin
    stall  = ((state_q == StIdle) && start && !flush) || (state_q == StRun) ||
             (state_q == StFix);
    done   = (state_q == StDone);
    result = result_q;
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed self-checking bench for ex_muldiv_unit.
module tb_ex_muldiv_unit;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
  } vec_t;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        flush;
  logic        stall;
  logic        done;
  logic [31:0] result;

  int total;
  int bad;
  vec_t vecs[$];

  ex_muldiv_unit #(
    .XLEN (32)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .op       (op),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .flush    (flush),
    .stall    (stall),
    .done     (done),
    .result   (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add_vec(input string name, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] res, input int lat);
    vec_t v;
    v.name = name;
    v.op   = o;
    v.a    = a;
    v.b    = b;
    v.res  = res;
    v.lat  = lat;
    vecs.push_back(v);
  endtask

  // Issue one op at a negedge; report cycles-to-done, stalled cycles and result.
  // When hold is set, start stays high through the DONE cycle.
  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic hold, output int lat, output int stalls,
                       output logic [31:0] res);
    lat    = -1;
    stalls = 0;
    res    = 'x;
    @(negedge clk);
    start    = 1'b1;
    op       = o;
    rs1_data = a;
    rs2_data = b;
    #1;
    if (stall) stalls++;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      // Operands must be ignored after capture.
      if (c == 2) begin
        rs1_data = ~a;
        rs2_data = 32'h0000_0003;
      end
      if (stall) stalls++;
      if (done) begin
        lat = c;
        res = result;
        break;
      end
    end
    if (hold) @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int          lat;
    int          stalls;
    int          pulses;
    logic [31:0] res;

    total    = 0;
    bad      = 0;
    reset_n  = 1'b0;
    start    = 1'b0;
    flush    = 1'b0;
    op       = 3'd0;
    rs1_data = '0;
    rs2_data = '0;

    add_vec("mul_7_m3",      3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
    add_vec("mulhu_m1_m1",   3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
    add_vec("mulh_m1_m1",    3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 34);
    add_vec("mulhsu_m1_2",   3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 34);
    add_vec("mulh_min_min",  3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
    add_vec("mul_shift",     3'd0, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 34);
    add_vec("div_m7_2",      3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 34);
    add_vec("rem_m7_2",      3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 34);
    add_vec("divu_100_7",    3'd5, 32'd100,       32'd7,         32'd14,        34);
    add_vec("remu_100_7",    3'd7, 32'd100,       32'd7,         32'd2,         34);
    add_vec("divu_by_zero",  3'd5, 32'h0000_1234, 32'h0000_0000, 32'hFFFF_FFFF, 1);
    add_vec("remu_by_zero",  3'd7, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 1);
    add_vec("div_ovf",       3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    add_vec("rem_ovf",       3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);
    add_vec("div_7_m3",      3'd4, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 34);
    add_vec("rem_7_m3",      3'd6, 32'h0000_0007, 32'hFFFF_FFFD, 32'h0000_0001, 34);

    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    chk("reset_done",   {31'd0, done},  32'd0);
    chk("reset_stall",  {31'd0, stall}, 32'd0);
    chk("reset_result", result,         32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Table-driven vectors.
    foreach (vecs[i]) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, lat, stalls, res);
      chk({vecs[i].name, "_res"},    res,         vecs[i].res);
      chk({vecs[i].name, "_lat"},    32'(lat),    32'(vecs[i].lat));
      chk({vecs[i].name, "_stalls"}, 32'(stalls), 32'(vecs[i].lat));
      @(negedge clk);
      chk({vecs[i].name, "_one_pulse"}, {31'd0, done}, 32'd0);
    end

    // Flush in RUN cycle 10 with start still asserted: abort, no done pulse.
    @(negedge clk);
    start    = 1'b1;
    op       = 3'd0;
    rs1_data = 32'd9;
    rs2_data = 32'd9;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    start = 1'b0;
    #1;
    chk("flush_stall", {31'd0, stall}, 32'd0);
    chk("flush_done",  {31'd0, done},  32'd0);
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk("flush_no_pulse",   32'(pulses), 32'd0);
    chk("flush_result_kept", result,     32'h0000_0001);

    // New op after the flush completes normally.
    do_op(3'd5, 32'd100, 32'd7, 1'b0, lat, stalls, res);
    chk("post_flush_res", res,      32'd14);
    chk("post_flush_lat", 32'(lat), 32'd34);

    // Start held through the DONE cycle yields exactly one pulse.
    pulses = 0;
    fork
      do_op(3'd0, 32'd3, 32'd5, 1'b1, lat, stalls, res);
      for (int c = 0; c < 45; c++) begin
        @(posedge clk);
        #1;
        if (done) pulses++;
      end
    join
    chk("hold_res",    res,          32'd15);
    chk("hold_pulses", 32'(pulses),  32'd1);

    // Asynchronous reset in the middle of RUN.
    @(negedge clk);
    start    = 1'b1;
    op       = 3'd5;
    rs1_data = 32'd1000;
    rs2_data = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("areset_done",   {31'd0, done},  32'd0);
    chk("areset_result", result,         32'd0);
    chk("areset_stall",  {31'd0, stall}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk("areset_no_pulse", 32'(pulses), 32'd0);

    do_op(3'd7, 32'd1000, 32'd3, 1'b0, lat, stalls, res);
    chk("post_reset_res", res,      32'd1);
    chk("post_reset_lat", 32'(lat), 32'd34);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
